dsp_mult_stream_adapter: RTL and testbench

- Handshaked front/back end for the qlf_k6n10f DSP multiplier (dsp_t1_sim / DSP hard block in multiply mode).
- Takes operand pairs from a valid/ready stream and drives the DSP a/b/unsigned inputs.
- Samples the DSP z output after a fixed latency and returns results in order on a valid/ready stream.
- A credit-counted result FIFO absorbs downstream backpressure, so no result is ever dropped.

---
 rtl/dsp_mult_stream_adapter.sv | 121 ++++++++++++
 tb/tb_dsp_mult_stream_adapter.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dsp_mult_stream_adapter.sv
// Valid/ready wrapper around a fixed-latency DSP multiplier: registers operands onto the
// DSP inputs, captures z after DSP_LATENCY edges into a FWFT FIFO guarded by a credit count.
module dsp_mult_stream_adapter #(
    parameter int A_WIDTH     = 20,
    parameter int B_WIDTH     = 18,
    parameter int Z_WIDTH     = 38,
    parameter int DSP_LATENCY = 0,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                             clock_i,
    input  logic                             reset_n_i,
    input  logic                             s_valid_i,
    output logic                             s_ready_o,
    input  logic [A_WIDTH-1:0]               s_a_i,
    input  logic [B_WIDTH-1:0]               s_b_i,
    input  logic                             s_unsigned_a_i,
    input  logic                             s_unsigned_b_i,
    output logic [A_WIDTH-1:0]               dsp_a_o,
    output logic [B_WIDTH-1:0]               dsp_b_o,
    output logic                             dsp_unsigned_a_o,
    output logic                             dsp_unsigned_b_o,
    input  logic [Z_WIDTH-1:0]               dsp_z_i,
    output logic                             m_valid_o,
    input  logic                             m_ready_i,
    output logic [Z_WIDTH-1:0]               m_z_o,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]  inflight_o
);

    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int VW = DSP_LATENCY + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

    logic [A_WIDTH-1:0] dsp_a_q, dsp_a_d;
    logic [B_WIDTH-1:0] dsp_b_q, dsp_b_d;
    logic               dsp_ua_q, dsp_ua_d;
    logic               dsp_ub_q, dsp_ub_d;
    logic [VW-1:0]      vld_q, vld_d;
    logic [CW-1:0]      inflight_q, inflight_d;
    logic [CW-1:0]      count_q, count_d;
    logic [PW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [Z_WIDTH-1:0] mem_q [FIFO_DEPTH];

    logic accept, push, pop;

    // Credits cover pipeline plus FIFO, so a capture always finds a free slot.
    assign s_ready_o = reset_n_i & (inflight_q < DEPTH_C);
    assign accept    = s_valid_i & s_ready_o;
    assign push      = vld_q[DSP_LATENCY];
    assign pop       = m_valid_o & m_ready_i;

    assign dsp_a_o          = dsp_a_q;
    assign dsp_b_o          = dsp_b_q;
    assign dsp_unsigned_a_o = dsp_ua_q;
    assign dsp_unsigned_b_o = dsp_ub_q;
    assign m_valid_o        = (count_q != '0);
    assign m_z_o            = mem_q[rd_ptr_q];
    assign inflight_o       = inflight_q;

    always_comb begin
        dsp_a_d  = dsp_a_q;
        dsp_b_d  = dsp_b_q;
        dsp_ua_d = dsp_ua_q;
        dsp_ub_d = dsp_ub_q;
        if (accept) begin
            dsp_a_d  = s_a_i;
            dsp_b_d  = s_b_i;
            dsp_ua_d = s_unsigned_a_i;
            dsp_ub_d = s_unsigned_b_i;
        end

        vld_d = (vld_q << 1) | VW'(accept);

        case ({accept, pop})
            2'b10:   inflight_d = inflight_q + CW'(1);
            2'b01:   inflight_d = inflight_q - CW'(1);
            default: inflight_d = inflight_q;
        endcase

        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        wr_ptr_d = wr_ptr_q + PW'(push);
        rd_ptr_d = rd_ptr_q + PW'(pop);
    end

    always_ff @(posedge clock_i) begin
        if (!reset_n_i) begin
            dsp_a_q    <= '0;
            dsp_b_q    <= '0;
            dsp_ua_q   <= 1'b0;
            dsp_ub_q   <= 1'b0;
            vld_q      <= '0;
            inflight_q <= '0;
            count_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            dsp_a_q    <= dsp_a_d;
            dsp_b_q    <= dsp_b_d;
            dsp_ua_q   <= dsp_ua_d;
            dsp_ub_q   <= dsp_ub_d;
            vld_q      <= vld_d;
            inflight_q <= inflight_d;
            count_q    <= count_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            if (push) begin
                mem_q[wr_ptr_q] <= dsp_z_i;
            end
        end
    end

endmodule

// File: tb/tb_dsp_mult_stream_adapter.sv
// Directed/streaming bench: one adapter on a combinational DSP model, one on a 2-stage model.
module tb_dsp_mult_stream_adapter;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [37:0] mul(input logic [19:0] a, input logic [17:0] b,
                                        input logic ua, input logic ub);
        logic [37:0] ax, bx;
        ax = ua ? {18'b0, a} : {{18{a[19]}}, a};
        bx = ub ? {20'b0, b} : {{20{b[17]}}, b};
        return ax * bx;
    endfunction

    // Instance 0: combinational DSP
    logic        s_valid0 = 0, s_ready0, ua0 = 0, ub0 = 0, m_ready0 = 0, m_valid0;
    logic [19:0] s_a0 = 0, dsp_a0;
    logic [17:0] s_b0 = 0, dsp_b0;
    logic        dua0, dub0;
    logic [37:0] dsp_z0, m_z0;
    logic [2:0]  inflight0;
    assign dsp_z0 = mul(dsp_a0, dsp_b0, dua0, dub0);

    dsp_mult_stream_adapter #(.DSP_LATENCY(0)) dut0 (
        .clock_i(clk), .reset_n_i(rst_n),
        .s_valid_i(s_valid0), .s_ready_o(s_ready0), .s_a_i(s_a0), .s_b_i(s_b0),
        .s_unsigned_a_i(ua0), .s_unsigned_b_i(ub0),
        .dsp_a_o(dsp_a0), .dsp_b_o(dsp_b0), .dsp_unsigned_a_o(dua0), .dsp_unsigned_b_o(dub0),
        .dsp_z_i(dsp_z0), .m_valid_o(m_valid0), .m_ready_i(m_ready0), .m_z_o(m_z0),
        .inflight_o(inflight0));

    // Instance 2: two-stage registered DSP
    logic        s_valid2 = 0, s_ready2, ua2 = 0, ub2 = 0, m_ready2 = 0, m_valid2;
    logic [19:0] s_a2 = 0, dsp_a2;
    logic [17:0] s_b2 = 0, dsp_b2;
    logic        dua2, dub2;
    logic [37:0] dsp_st1, dsp_z2, m_z2;
    logic [2:0]  inflight2;
    always @(posedge clk) begin
        dsp_st1 <= mul(dsp_a2, dsp_b2, dua2, dub2);
        dsp_z2  <= dsp_st1;
    end

    dsp_mult_stream_adapter #(.DSP_LATENCY(2)) dut2 (
        .clock_i(clk), .reset_n_i(rst_n),
        .s_valid_i(s_valid2), .s_ready_o(s_ready2), .s_a_i(s_a2), .s_b_i(s_b2),
        .s_unsigned_a_i(ua2), .s_unsigned_b_i(ub2),
        .dsp_a_o(dsp_a2), .dsp_b_o(dsp_b2), .dsp_unsigned_a_o(dua2), .dsp_unsigned_b_o(dub2),
        .dsp_z_i(dsp_z2), .m_valid_o(m_valid2), .m_ready_i(m_ready2), .m_z_o(m_z2),
        .inflight_o(inflight2));

    // Scoreboards: sample on the falling edge, decide what the next rising edge does
    logic [37:0] q0[$], q2[$];
    int acc0 = 0, pop0 = 0, acc2 = 0, pop2 = 0;

    always @(negedge clk) begin
        if (!rst_n) begin
            q0.delete();
        end else begin
            check_val("inflight0", 64'(inflight0), 64'(q0.size()));
            check_val("s_ready0", 64'(s_ready0), 64'(q0.size() < 4));
            if (m_valid0 && m_ready0) begin
                if (q0.size() == 0) check_val("spurious0", 64'(m_valid0), 64'd0);
                else check_val("z0", 64'(m_z0), 64'(q0.pop_front()));
                pop0++;
            end
            if (s_valid0 && s_ready0) begin
                q0.push_back(mul(s_a0, s_b0, ua0, ub0));
                acc0++;
            end
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            q2.delete();
        end else begin
            check_val("inflight2", 64'(inflight2), 64'(q2.size()));
            if (inflight2 > 3'd4) check_val("inflight2_max", 64'(inflight2), 64'd4);
            if (m_valid2 && m_ready2) begin
                if (q2.size() == 0) check_val("spurious2", 64'(m_valid2), 64'd0);
                else check_val("z2", 64'(m_z2), 64'(q2.pop_front()));
                pop2++;
            end
            if (s_valid2 && s_ready2) begin
                q2.push_back(mul(s_a2, s_b2, ua2, ub2));
                acc2++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain0();
        s_valid0 = 0;
        m_ready0 = 1;
        for (int i = 0; i < 20 && inflight0 != 0; i++) tick();
        check_val("drain0", 64'(inflight0), 64'd0);
        m_ready0 = 0;
    endtask

    initial begin
        int idx, cyc, lows, stalls;
        logic [19:0] bp_a [10];
        logic [17:0] bp_b [10];

        // Reset
        rst_n = 0;
        repeat (3) tick();
        check_val("rst_s_ready", 64'(s_ready0), 64'd0);
        check_val("rst_m_valid", 64'(m_valid0), 64'd0);
        check_val("rst_inflight", 64'(inflight0), 64'd0);
        check_val("rst_dsp_a", 64'(dsp_a0), 64'd0);
        check_val("rst_m_z", 64'(m_z0), 64'd0);
        rst_n = 1;
        #1;
        check_val("rel_s_ready", 64'(s_ready0), 64'd1);

        // Signed single op: -3 * 7
        s_valid0 = 1; s_a0 = 20'hFFFFD; s_b0 = 18'd7; ua0 = 0; ub0 = 0;
        tick();
        s_valid0 = 0;
        check_val("sgn_inflight", 64'(inflight0), 64'd1);
        check_val("sgn_valid_early", 64'(m_valid0), 64'd0);
        check_val("sgn_dsp_a", 64'(dsp_a0), 64'hFFFFD);
        check_val("sgn_dsp_b", 64'(dsp_b0), 64'd7);
        tick();
        check_val("sgn_valid", 64'(m_valid0), 64'd1);
        check_val("sgn_z", 64'(m_z0), 64'h3F_FFFF_FFEB);
        m_ready0 = 1;
        tick();
        m_ready0 = 0;
        check_val("sgn_pop_valid", 64'(m_valid0), 64'd0);
        check_val("sgn_pop_inflight", 64'(inflight0), 64'd0);

        // Unsigned corner
        s_valid0 = 1; s_a0 = 20'hFFFFF; s_b0 = 18'h3FFFF; ua0 = 1; ub0 = 1;
        tick();
        s_valid0 = 0; ua0 = 0; ub0 = 0;
        tick();
        check_val("uns_valid", 64'(m_valid0), 64'd1);
        check_val("uns_z", 64'(m_z0), 64'h3F_FFEC_0001);
        drain0();

        // Backpressure: 10 distinct ops against a stalled sink
        for (int i = 0; i < 10; i++) begin
            bp_a[i] = 20'(i * 1001 + 5);
            bp_b[i] = 18'(-(i * 37 + 2));
        end
        idx = 0;
        m_ready0 = 0;
        for (int c = 0; c < 8; c++) begin
            s_valid0 = 1; s_a0 = bp_a[idx]; s_b0 = bp_b[idx];
            if (s_ready0) idx++;
            tick();
        end
        check_val("bp_accepted", 64'(idx), 64'd4);
        check_val("bp_s_ready", 64'(s_ready0), 64'd0);
        check_val("bp_inflight", 64'(inflight0), 64'd4);
        m_ready0 = 1;
        cyc = 0;
        while (idx < 10 && cyc < 100) begin
            s_valid0 = 1; s_a0 = bp_a[idx]; s_b0 = bp_b[idx];
            if (s_ready0) idx++;
            tick();
            cyc++;
        end
        check_val("bp_all_accepted", 64'(idx), 64'd10);
        drain0();
        check_val("bp_pop_count", 64'(pop0), 64'd12);

        // Streaming 1000 random signed pairs
        m_ready0 = 1;
        lows = 0; stalls = 0;
        for (int i = 0; i < 1000; i++) begin
            s_valid0 = 1; s_a0 = 20'($urandom); s_b0 = 18'($urandom);
            if (!s_ready0) stalls++;
            if (i >= 2 && !m_valid0) lows++;
            tick();
        end
        check_val("stream_stalls", 64'(stalls), 64'd0);
        check_val("stream_gaps", 64'(lows), 64'd0);
        drain0();
        check_val("stream_pops", 64'(pop0), 64'(acc0));

        // Reset mid-flight
        m_ready0 = 0;
        for (int i = 0; i < 3; i++) begin
            s_valid0 = 1; s_a0 = 20'(i + 9); s_b0 = 18'(i + 11);
            tick();
        end
        s_valid0 = 0;
        check_val("mid_inflight", 64'(inflight0), 64'd3);
        rst_n = 0;
        tick();
        check_val("mid_rst_valid", 64'(m_valid0), 64'd0);
        check_val("mid_rst_inflight", 64'(inflight0), 64'd0);
        rst_n = 1;
        m_ready0 = 1;
        lows = 0;
        for (int i = 0; i < 4; i++) begin
            if (m_valid0) lows++;
            tick();
        end
        check_val("mid_stale", 64'(lows), 64'd0);
        s_valid0 = 1; s_a0 = 20'd123; s_b0 = 18'(-45); ua0 = 0; ub0 = 0;
        tick();
        s_valid0 = 0;
        tick();
        check_val("mid_new_valid", 64'(m_valid0), 64'd1);
        check_val("mid_new_z", 64'(m_z0), 64'h3F_FFFF_EA61);
        drain0();

        // Latency-2 instance, random sink stalls
        cyc = 0;
        while (acc2 < 300 && cyc < 5000) begin
            s_valid2 = 1;
            s_a2 = 20'($urandom); s_b2 = 18'($urandom);
            ua2 = 1'($urandom); ub2 = 1'($urandom);
            m_ready2 = 1'($urandom);
            tick();
            cyc++;
        end
        check_val("lat2_accepted", 64'(acc2), 64'd300);
        s_valid2 = 0;
        m_ready2 = 1;
        for (int i = 0; i < 50 && (inflight2 != 0 || q2.size() != 0); i++) tick();
        check_val("lat2_drain", 64'(q2.size()), 64'd0);
        check_val("lat2_pops", 64'(pop2), 64'(acc2));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
